if_delay_pipe: RTL and testbench
================================

// Module: if_delay_pipe
// PURPOSE
//  Parametrised IF->ID delay pipeline; replaces hand-instantiated per-stage delay registers with one block.
//  Carries instruction, PC and PC+4 through DEPTH stages.
//  Each stage has a valid bit; bubbles are marked invalid rather than NOP-encoded.
//  Honours STALL and FLUSH; COLLAPSE mode squeezes bubbles during stalls; upstream handshake; flush perf counter.
// PARAMETERS
//  DEPTH     7       number of register stages (>=1); latency in cycles when unstalled
//  DATA_W    32      width of instruction / PC fields
//  COLLAPSE  0       1: an invalid stage may be overwritten by its predecessor while STALL is high
//  CNT_W     16      width of Flushed_Count
// PORTS
//  CLK                  in   1        clock, rising edge
//  RESET                in   1        asynchronous, active-high reset
//  STALL                in   1        consumer (ID) cannot accept this cycle; oldest stage must hold
//  FLUSH                in   1        discard all in-flight instructions (branch mispredict)
//  Valid_IN             in   1        Instr_IN / PC fields hold a fetched instruction
//  Instr_IN             in   DATA_W   fetched instruction
//  Instr_PC_IN          in   DATA_W   its PC
//  Instr_PC_Plus4_IN    in   DATA_W   its PC+4
//  Ready_OUT            out  1        stage 0 accepts input this cycle (combinational)
//  Valid_OUT            out  1        oldest stage holds a valid instruction
//  Instr_OUT            out  DATA_W   oldest stage instruction; NOP_INSTR when Valid_OUT=0
//  Instr_PC_OUT         out  DATA_W   oldest stage PC; 0 when Valid_OUT=0
//  Instr_PC_Plus4_OUT   out  DATA_W   oldest stage PC+4; 0 when Valid_OUT=0
//  Stage_Valid          out  DEPTH    per-stage valid bits; bit 0 youngest, bit DEPTH-1 oldest
//  Occupancy            out  $clog2(DEPTH+1)  popcount of Stage_Valid
//  Flushed_Count        out  CNT_W    saturating count of valid instructions discarded by FLUSH
// BEHAVIOUR
//  Reset: all stage valids 0; all data regs 0; Valid_OUT=0; Instr_OUT=NOP_INSTR; Occupancy=0; Flushed_Count=0.
//  Advance enables (combinational), stage k, k=DEPTH-1 oldest:
//   adv[DEPTH-1] = ~STALL.
//   COLLAPSE=0: adv[k] = ~STALL for all k (whole pipe freezes as one).
//   COLLAPSE=1: adv[k] = adv[k+1] | ~valid[k+1]  (stage moves into an empty slot ahead of it).
//   Ready_OUT = adv[0] & ~FLUSH.
//  Clock edge, no FLUSH: stage k with adv[k]: takes stage k-1 (stage 0 takes inputs, valid=Valid_IN&Ready_OUT).
//   A stage that advances without receiving data (predecessor held) becomes invalid.
//   A stage with adv[k]=0 holds its contents and valid.
//  Latency: unstalled, input in cycle t appears on outputs in cycle t+DEPTH.
//  FLUSH (priority over STALL): next edge clears every valid and zeroes data; inputs of the same cycle are
//   dropped and not counted; Flushed_Count += popcount(valid), saturating at 2^CNT_W-1.
//  FLUSH and STALL together: flush occurs; pipe is empty next cycle.
//  Outputs are driven from the oldest stage register (no combinational input-to-output path) except Ready_OUT.
//  Invalid instructions never reach ID as valid; Instr_OUT masked to NOP_INSTR when invalid.
//  RESET asserted mid-operation: immediate asynchronous clear as at reset; counter also cleared.
//  Occupancy is updated in the same edge as the valids (registered or derived from registered valids).
// STRUCTURE
//  Shared package pipe_pkg: NOP_INSTR (32'h0000_0000), DATA_W default, stage record field widths.
//  Sub-module if_delay_stage: one stage register (valid + 3 data fields, load/clear/hold controls).
//   Top instantiates DEPTH of them in a generate loop, plus adv chain, popcount, and counter.
// TESTING
//  1 DEPTH=7, COLLAPSE=0: issue PC 0x400000..0x40001C back-to-back -> PC 0x400000 on Instr_PC_OUT at cycle 7, then one per cycle.
//  2 Pipe full, STALL high 3 cycles -> outputs, Stage_Valid=7'h7F and Occupancy=7 constant; Ready_OUT=0; resumes in order.
//  3 COLLAPSE=1, pattern V,-,V,-,V,-,V then STALL high -> after 3 cycles Stage_Valid=7'h78; Ready_OUT stays 1 until full.
//  4 Occupancy=5, FLUSH with Valid_IN=1 and STALL=1 -> next cycle Stage_Valid=0, Valid_OUT=0, Instr_OUT=NOP_INSTR, Flushed_Count+=5.
//  5 CNT_W=3, repeated flushes of full pipe -> Flushed_Count saturates at 7, never wraps.
//  6 RESET pulsed between clock edges mid-stream -> all outputs return to reset values before next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF->ID delay pipeline: default widths,
// the NOP encoding presented to ID for bubbles, and the per-stage action codes.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 7;
  localparam int CNT_W_DEF  = 16;

  // Instruction word driven to ID whenever the oldest stage is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Action applied to one stage register on the next clock edge
  typedef enum logic [1:0] {
    STAGE_HOLD  = 2'd0,  // keep valid and data
    STAGE_LOAD  = 2'd1,  // take predecessor (or pipeline input)
    STAGE_KILL  = 2'd2,  // contents moved on, nothing replaced them
    STAGE_CLEAR = 2'd3   // flush: drop contents
  } stage_op_e;

endpackage

// File: rtl/if_delay_stage.sv
// One slot of the IF->ID delay pipeline: a valid bit plus instruction,
// PC and PC+4, updated according to a single action code per cycle.
module if_delay_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] pc4_d,
  output logic              valid_q,
  output logic [DATA_W-1:0] instr_q,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] pc4_q
);

  // Slot register: load, invalidate/clear (data zeroed so bubbles carry no stale fields) or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      case (stage_op_e'(op))
        STAGE_LOAD: begin
          valid_q <= valid_d;
          instr_q <= instr_d;
          pc_q    <= pc_d;
          pc4_q   <= pc4_d;
        end
        STAGE_KILL, STAGE_CLEAR: begin
          valid_q <= 1'b0;
          instr_q <= '0;
          pc_q    <= '0;
          pc4_q   <= '0;
        end
        STAGE_HOLD: begin
          valid_q <= valid_q;
          instr_q <= instr_q;
          pc_q    <= pc_q;
          pc4_q   <= pc4_q;
        end
        default: begin
          valid_q <= valid_q;
          instr_q <= instr_q;
          pc_q    <= pc_q;
          pc4_q   <= pc4_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_delay_pipe.sv
// IF->ID delay pipeline of DEPTH slots. adv_s[k] means "the contents of
// slot k move on this cycle" (into slot k+1, or out to ID for the oldest
// slot); slot k therefore loads whenever adv_s[k-1] is set, and becomes a
// bubble when its own contents leave without a replacement. With COLLAPSE
// set, a slot may move into an empty slot ahead of it even while ID stalls,
// squeezing bubbles out of the pipe.
module if_delay_pipe
  import pipe_pkg::*;
#(
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int COLLAPSE = 0,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              Valid_IN,
  input  logic [DATA_W-1:0] Instr_IN,
  input  logic [DATA_W-1:0] Instr_PC_IN,
  input  logic [DATA_W-1:0] Instr_PC_Plus4_IN,
  output logic              Ready_OUT,
  output logic              Valid_OUT,
  output logic [DATA_W-1:0] Instr_OUT,
  output logic [DATA_W-1:0] Instr_PC_OUT,
  output logic [DATA_W-1:0] Instr_PC_Plus4_OUT,
  output logic [DEPTH-1:0]  Stage_Valid,
  output logic [OCC_W-1:0]  Occupancy,
  output logic [CNT_W-1:0]  Flushed_Count
);

  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP_INSTR);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [DEPTH-1:0]  valid_s;
  logic [DATA_W-1:0] instr_s [DEPTH];
  logic [DATA_W-1:0] pc_s    [DEPTH];
  logic [DATA_W-1:0] pc4_s   [DEPTH];
  logic [DEPTH-1:0]  adv_s;
  logic [OCC_W-1:0]  occ_s;
  logic [SUM_W-1:0]  flush_sum_s;
  logic [CNT_W-1:0]  count_next_s;
  logic [CNT_W-1:0]  count_r;

  // Advance chain, evaluated from the oldest slot backwards
  always_comb begin
    adv_s = '0;
    adv_s[DEPTH-1] = ~STALL;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (COLLAPSE != 0) begin
        adv_s[k] = adv_s[k+1] | ~valid_s[k+1];
      end else begin
        adv_s[k] = ~STALL;
      end
    end
  end

  // Upstream may hand over an instruction only when slot 0 is moving and no flush is pending
  assign Ready_OUT = adv_s[0] & ~FLUSH;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic              load_s;
    logic [1:0]        op_s;
    logic              src_valid_s;
    logic [DATA_W-1:0] src_instr_s;
    logic [DATA_W-1:0] src_pc_s;
    logic [DATA_W-1:0] src_pc4_s;

    if (g == 0) begin : g_head
      assign load_s      = adv_s[0];
      assign src_valid_s = Valid_IN & Ready_OUT;
      assign src_instr_s = Instr_IN;
      assign src_pc_s    = Instr_PC_IN;
      assign src_pc4_s   = Instr_PC_Plus4_IN;
    end else begin : g_body
      assign load_s      = adv_s[g-1];
      assign src_valid_s = valid_s[g-1];
      assign src_instr_s = instr_s[g-1];
      assign src_pc_s    = pc_s[g-1];
      assign src_pc4_s   = pc4_s[g-1];
    end

    // Choose this slot's action: flush wins, then refill, then bubble on departure, else hold
    always_comb begin
      op_s = STAGE_HOLD;
      if (FLUSH) begin
        op_s = STAGE_CLEAR;
      end else if (load_s) begin
        op_s = STAGE_LOAD;
      end else if (adv_s[g]) begin
        op_s = STAGE_KILL;
      end else begin
        op_s = STAGE_HOLD;
      end
    end

    if_delay_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk     (CLK),
      .rst     (RESET),
      .op      (op_s),
      .valid_d (src_valid_s),
      .instr_d (src_instr_s),
      .pc_d    (src_pc_s),
      .pc4_d   (src_pc4_s),
      .valid_q (valid_s[g]),
      .instr_q (instr_s[g]),
      .pc_q    (pc_s[g]),
      .pc4_q   (pc4_s[g])
    );
  end

  // Number of occupied slots, derived from the registered valids
  always_comb begin
    occ_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_s = occ_s + OCC_W'(valid_s[k]);
    end
  end

  // Saturating sum of the flush counter and the instructions about to be discarded
  always_comb begin
    flush_sum_s  = SUM_W'(count_r) + SUM_W'(occ_s);
    count_next_s = count_r;
    if (flush_sum_s > SUM_W'(CNT_MAX)) begin
      count_next_s = CNT_MAX;
    end else begin
      count_next_s = flush_sum_s[CNT_W-1:0];
    end
  end

  // Flush performance counter, only advances on a flush edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_r <= '0;
    end else if (FLUSH) begin
      count_r <= count_next_s;
    end else begin
      count_r <= count_r;
    end
  end

  // ID sees the oldest slot; empty slots are presented as NOP with zero PCs
  assign Valid_OUT          = valid_s[DEPTH-1];
  assign Instr_OUT          = valid_s[DEPTH-1] ? instr_s[DEPTH-1] : NOP_W;
  assign Instr_PC_OUT       = valid_s[DEPTH-1] ? pc_s[DEPTH-1]    : '0;
  assign Instr_PC_Plus4_OUT = valid_s[DEPTH-1] ? pc4_s[DEPTH-1]   : '0;
  assign Stage_Valid        = valid_s;
  assign Occupancy          = occ_s;
  assign Flushed_Count      = count_r;

endmodule

// File: tb/tb_if_delay_pipe.sv
// Bench for if_delay_pipe: two instances (plain freeze, and bubble-collapsing)
// driven with the same stimulus and compared every cycle against a slot-level
// reference model of instructions moving through the pipe.
module tb_if_delay_pipe;
  import pipe_pkg::*;

  localparam int D = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, vin;
  logic [31:0] ins, pc, p4;

  logic        rdy  [2];
  logic        vout [2];
  logic [31:0] iout [2];
  logic [31:0] pco  [2];
  logic [31:0] p4o  [2];
  logic [6:0]  sv   [2];
  logic [2:0]  occ  [2];
  logic [2:0]  fc0;
  logic [15:0] fc1;

  always #5 clk = ~clk;

  if_delay_pipe #(.DEPTH(D), .DATA_W(32), .COLLAPSE(0), .CNT_W(3)) dut0 (
    .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .Valid_IN(vin),
    .Instr_IN(ins), .Instr_PC_IN(pc), .Instr_PC_Plus4_IN(p4),
    .Ready_OUT(rdy[0]), .Valid_OUT(vout[0]), .Instr_OUT(iout[0]),
    .Instr_PC_OUT(pco[0]), .Instr_PC_Plus4_OUT(p4o[0]),
    .Stage_Valid(sv[0]), .Occupancy(occ[0]), .Flushed_Count(fc0));

  if_delay_pipe #(.DEPTH(D), .DATA_W(32), .COLLAPSE(1), .CNT_W(16)) dut1 (
    .CLK(clk), .RESET(rst), .STALL(stall), .FLUSH(flush), .Valid_IN(vin),
    .Instr_IN(ins), .Instr_PC_IN(pc), .Instr_PC_Plus4_IN(p4),
    .Ready_OUT(rdy[1]), .Valid_OUT(vout[1]), .Instr_OUT(iout[1]),
    .Instr_PC_OUT(pco[1]), .Instr_PC_Plus4_OUT(p4o[1]),
    .Stage_Valid(sv[1]), .Occupancy(occ[1]), .Flushed_Count(fc1));

  // Reference model: which slots hold an instruction, and what it is
  logic        m_v  [2][D];
  logic [31:0] m_i  [2][D];
  logic [31:0] m_pc [2][D];
  logic [31:0] m_p4 [2][D];
  int          m_fc [2];
  int          m_max [2] = '{7, 65535};

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // An instruction in slot k moves on when ID drains the pipe, or (collapse
  // mode) when any slot between it and ID is empty.
  function automatic bit m_move(input int d, input int k);
    bit hole;
    hole = 1'b0;
    for (int j = k + 1; j < D; j++) if (!m_v[d][j]) hole = 1'b1;
    return !stall || (d == 1 && hole);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_fc[d] = 0;
      for (int k = 0; k < D; k++) begin
        m_v[d][k] = 1'b0; m_i[d][k] = '0; m_pc[d][k] = '0; m_p4[d][k] = '0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic        nv [D];
      logic [31:0] ni [D];
      logic [31:0] np [D];
      logic [31:0] n4 [D];
      bit          mv [D];
      int          cnt;
      for (int k = 0; k < D; k++) begin
        nv[k] = 1'b0; ni[k] = '0; np[k] = '0; n4[k] = '0;
        mv[k] = m_move(d, k);
      end
      if (flush) begin
        cnt = 0;
        for (int k = 0; k < D; k++) if (m_v[d][k]) cnt++;
        m_fc[d] = (m_fc[d] + cnt > m_max[d]) ? m_max[d] : m_fc[d] + cnt;
      end else begin
        for (int k = 0; k < D; k++) begin
          if (m_v[d][k]) begin
            if (!mv[k]) begin
              nv[k] = 1'b1; ni[k] = m_i[d][k]; np[k] = m_pc[d][k]; n4[k] = m_p4[d][k];
            end else if (k < D - 1) begin
              nv[k+1] = 1'b1; ni[k+1] = m_i[d][k]; np[k+1] = m_pc[d][k]; n4[k+1] = m_p4[d][k];
            end
          end
        end
        if (mv[0] && vin) begin
          nv[0] = 1'b1; ni[0] = ins; np[0] = pc; n4[0] = p4;
        end
      end
      for (int k = 0; k < D; k++) begin
        m_v[d][k] = nv[k]; m_i[d][k] = ni[k]; m_pc[d][k] = np[k]; m_p4[d][k] = n4[k];
      end
    end
  endtask

  task automatic check_ready();
    for (int d = 0; d < 2; d++)
      check_val($sformatf("d%0d_ready", d), 64'(rdy[d]), 64'(m_move(d, 0) && !flush));
  endtask

  task automatic check_outs();
    for (int d = 0; d < 2; d++) begin
      logic [6:0] esv;
      int         eocc;
      logic       ov;
      eocc = 0;
      for (int k = 0; k < D; k++) begin
        esv[k] = m_v[d][k];
        if (m_v[d][k]) eocc++;
      end
      ov = m_v[d][D-1];
      check_val($sformatf("d%0d_valid_out", d), 64'(vout[d]), 64'(ov));
      check_val($sformatf("d%0d_instr_out", d), 64'(iout[d]), 64'(ov ? m_i[d][D-1] : NOP_INSTR));
      check_val($sformatf("d%0d_pc_out", d), 64'(pco[d]), 64'(ov ? m_pc[d][D-1] : 32'h0));
      check_val($sformatf("d%0d_pc4_out", d), 64'(p4o[d]), 64'(ov ? m_p4[d][D-1] : 32'h0));
      check_val($sformatf("d%0d_stage_valid", d), 64'(sv[d]), 64'(esv));
      check_val($sformatf("d%0d_occupancy", d), 64'(occ[d]), 64'(eocc));
      check_val($sformatf("d%0d_flushed", d), (d == 0) ? 64'(fc0) : 64'(fc1), 64'(m_fc[d]));
    end
  endtask

  // One cycle: drive inputs mid-cycle, check Ready, clock, update model, check outputs
  task automatic step(input logic s, input logic f, input logic v, input logic [31:0] a);
    stall = s; flush = f; vin = v; ins = $urandom; pc = a; p4 = a + 32'd4;
    #1;
    check_ready();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  initial begin
    int fc_before;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; vin = 1'b0; ins = '0; pc = '0; p4 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    rst = 1'b0;

    // Back-to-back issue, first PC must reach ID after DEPTH edges
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0040_0000 + 32'(4 * i));
      if (i == 6) check_val("t1_first_pc", 64'(pco[0]), 64'h0040_0000);
    end

    // Full pipe held by STALL
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, $urandom);
      check_val("t2_stage_valid", 64'(sv[0]), 64'h7F);
      check_val("t2_occupancy", 64'(occ[0]), 64'd7);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, $urandom);

    // Collapse: alternate valid/bubble, then stall and squeeze
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, ((i % 2) == 0), $urandom);
    check_val("t3_pattern", 64'(sv[1]), 64'h55);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    check_val("t3_squeezed", 64'(sv[1]), 64'h78);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, $urandom);

    // Flush of five in-flight instructions together with STALL and Valid_IN
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    check_val("t4_occupancy", 64'(occ[1]), 64'd5);
    fc_before = int'(fc1);
    step(1'b1, 1'b1, 1'b1, $urandom);
    check_val("t4_sv_clear", 64'(sv[1]), 64'h0);
    check_val("t4_flushed", 64'(fc1), 64'(fc_before + 5));

    // Repeated full flushes: 3-bit counter must stick at 7
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, $urandom);
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check_val("t5_saturated", 64'(fc0), 64'd7);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < 75), $urandom);

    // Make sure something is in flight, then reset between edges
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    rst = 1'b1;
    #2;
    model_reset();
    check_outs();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++)
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 75), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
